// File: rtl/inert_pkg.sv
// Shared types and constants for the iNEMO read sequencer.
// Defining INERT_AZ_EN extends the read burst with the Z-acceleration pair.
package inert_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    CFG_ISSUE,
    CFG_WAIT,
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    COMMIT
  } state_t;

  localparam logic READ_BIT = 1'b1;

  localparam logic [6:0] ADDR_PTCH_L = 7'h22;
  localparam logic [6:0] ADDR_PTCH_H = 7'h23;
  localparam logic [6:0] ADDR_ROLL_L = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H = 7'h25;
  localparam logic [6:0] ADDR_YAW_L  = 7'h26;
  localparam logic [6:0] ADDR_YAW_H  = 7'h27;
  localparam logic [6:0] ADDR_AX_L   = 7'h28;
  localparam logic [6:0] ADDR_AX_H   = 7'h29;
  localparam logic [6:0] ADDR_AY_L   = 7'h2A;
  localparam logic [6:0] ADDR_AY_H   = 7'h2B;
  localparam logic [6:0] ADDR_AZ_L   = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H   = 7'h2D;

  localparam logic [15:0] CFG_INT_DRDY  = 16'h0D02;
  localparam logic [15:0] CFG_ACCEL_ODR = 16'h1062;
  localparam logic [15:0] CFG_GYRO_ODR  = 16'h1162;
  localparam logic [15:0] CFG_ROUNDING  = 16'h1460;

  localparam int NUM_CFG = 4;
  localparam logic [15:0] CFG_WORDS [NUM_CFG] = '{
    CFG_INT_DRDY, CFG_ACCEL_ODR, CFG_GYRO_ODR, CFG_ROUNDING
  };

`ifdef INERT_AZ_EN
  localparam int NUM_RD = 12;
`else
  localparam int NUM_RD = 10;
`endif

  // Full address table; a burst walks only the first NUM_RD entries.
  localparam int MAX_RD = 12;
  localparam logic [6:0] RD_ADDR [MAX_RD] = '{
    ADDR_PTCH_L, ADDR_PTCH_H, ADDR_ROLL_L, ADDR_ROLL_H,
    ADDR_YAW_L,  ADDR_YAW_H,  ADDR_AX_L,   ADDR_AX_H,
    ADDR_AY_L,   ADDR_AY_H,   ADDR_AZ_L,   ADDR_AZ_H
  };

  function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
    return {READ_BIT, addr, 8'h00};
  endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for an asynchronous interrupt line plus a
// rising-edge detector that yields a one-cycle pulse in the clk domain.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // Fewer than two stages would not give metastability protection.
  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync;
  logic         prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], din};
      prev <= sync[N-1];
    end
  end

  assign rise = sync[N-1] & ~prev;

endmodule

// File: rtl/inert_rd_seq.sv
// iNEMO transaction sequencer: power-up wait, register config, then a burst of
// byte reads per data-ready interrupt. INERT_AZ_EN adds the az output and reads.
module inert_rd_seq
  import inert_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT    = 16'hFFFF,
  parameter int          INT_SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] ptch,
  output logic [15:0] roll,
  output logic [15:0] yaw,
  output logic [15:0] ax,
  output logic [15:0] ay,
`ifdef INERT_AZ_EN
  output logic [15:0] az,
`endif
  output logic        vld,
  output logic        init_done
);

  // Handshake with SPI_mnrch: wrt is a one-cycle start pulse that launches the
  // command in wt_data; wt_data stays put until the matching one-cycle done,
  // and no new wrt is issued before that done has been consumed.

  localparam logic [1:0] CFG_LAST = 2'(NUM_CFG - 1);
  localparam logic [3:0] RD_LAST  = 4'(NUM_RD - 1);

  state_t      state;
  logic [15:0] timer;
  logic        pending;
  logic [1:0]  cfg_idx;
  logic [3:0]  rd_idx;
  logic [1:0]  cfg_nxt;
  logic [3:0]  rd_nxt;
  logic        int_rise;
  logic [7:0]  sh      [NUM_RD];
  logic [7:0]  sh_next [NUM_RD];
  logic        unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign cfg_nxt      = cfg_idx + 2'd1;
  assign rd_nxt       = rd_idx + 4'd1;

  int_sync #(
    .STAGES(INT_SYNC_STG)
  ) u_int_sync (
    .clk (clk),
    .rst (rst),
    .din (INT),
    .rise(int_rise)
  );

  // Shadow bytes including the one arriving this cycle, so the final done can
  // publish the whole set immediately.
  always_comb begin
    sh_next = sh;
    if (state == RD_WAIT && done) begin
      sh_next[rd_idx] = rd_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWR_WAIT;
      timer     <= '0;
      pending   <= 1'b0;
      cfg_idx   <= '0;
      rd_idx    <= '0;
      wrt       <= 1'b0;
      wt_data   <= '0;
      ptch      <= '0;
      roll      <= '0;
      yaw       <= '0;
      ax        <= '0;
      ay        <= '0;
`ifdef INERT_AZ_EN
      az        <= '0;
`endif
      vld       <= 1'b0;
      init_done <= 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
        sh[i] <= '0;
      end
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;

      // A new edge beats the clear that happens when IDLE launches a burst.
      if (int_rise && init_done) begin
        pending <= 1'b1;
      end else if (state == IDLE && pending) begin
        pending <= 1'b0;
      end

      case (state)
        PWR_WAIT: begin
          if (timer == INIT_WAIT) begin
            state   <= CFG_ISSUE;
            wrt     <= 1'b1;
            wt_data <= CFG_WORDS[cfg_idx];
          end else begin
            timer <= timer + 16'd1;
          end
        end

        CFG_ISSUE: state <= CFG_WAIT;

        CFG_WAIT: begin
          if (done) begin
            if (cfg_idx == CFG_LAST) begin
              init_done <= 1'b1;
              cfg_idx   <= '0;
              state     <= IDLE;
            end else begin
              cfg_idx <= cfg_nxt;
              state   <= CFG_ISSUE;
              wrt     <= 1'b1;
              wt_data <= CFG_WORDS[cfg_nxt];
            end
          end
        end

        IDLE: begin
          if (pending) begin
            rd_idx  <= '0;
            state   <= RD_ISSUE;
            wrt     <= 1'b1;
            wt_data <= rd_cmd(RD_ADDR[0]);
          end
        end

        RD_ISSUE: state <= RD_WAIT;

        RD_WAIT: begin
          if (done) begin
            sh <= sh_next;
            if (rd_idx == RD_LAST) begin
              // Outputs and vld land together; COMMIT is the cycle vld is high.
              ptch  <= {sh_next[1], sh_next[0]};
              roll  <= {sh_next[3], sh_next[2]};
              yaw   <= {sh_next[5], sh_next[4]};
              ax    <= {sh_next[7], sh_next[6]};
              ay    <= {sh_next[9], sh_next[8]};
`ifdef INERT_AZ_EN
              az    <= {sh_next[11], sh_next[10]};
`endif
              vld   <= 1'b1;
              state <= COMMIT;
            end else begin
              rd_idx  <= rd_nxt;
              state   <= RD_ISSUE;
              wrt     <= 1'b1;
              wt_data <= rd_cmd(RD_ADDR[rd_nxt]);
            end
          end
        end

        COMMIT: state <= IDLE;

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_rd_seq.sv
// Self-checking bench for inert_rd_seq: behavioural SPI/iNEMO responder plus a
// transaction-level model of the command stream and the published samples.
module tb_inert_rd_seq;

`ifdef INERT_AZ_EN
  localparam int NOUT = 6;
`else
  localparam int NOUT = 5;
`endif
  localparam int NRD = 2 * NOUT;
  localparam int PW  = 16 * NOUT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = '0;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] ptch, roll, yaw, ax, ay;
`ifdef INERT_AZ_EN
  logic [15:0] az;
`endif
  logic        vld;
  logic        init_done;
  logic [PW-1:0] act_pkt;

  inert_rd_seq #(
    .INIT_WAIT   (16'h0010),
    .INT_SYNC_STG(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .INT      (INT),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .wt_data  (wt_data),
    .ptch     (ptch),
    .roll     (roll),
    .yaw      (yaw),
    .ax       (ax),
    .ay       (ay),
`ifdef INERT_AZ_EN
    .az       (az),
`endif
    .vld      (vld),
    .init_done(init_done)
  );

  assign act_pkt = {ptch, roll, yaw, ax, ay
`ifdef INERT_AZ_EN
                    , az
`endif
                   };

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [15:0]   cfg_words [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
  logic [7:0]    regs [128];
  logic [7:0]    rsp  [128];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] hold = '0;
  logic [15:0]   cur_cmd = '0;
  logic          busy = 1'b0;
  int            dly = 0;
  int            fixed_dly = 0;
  bit            inject_spur = 1'b0;
  int            n_wrt = 0;
  int            n_done = 0;
  int            n_vld = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected sample set: each output is {high byte, low byte} of consecutive
  // registers starting at 0x22, in port order.
  function automatic logic [PW-1:0] pack_exp();
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < NOUT; k++) begin
      p[16*(NOUT-1-k) +: 16] = {rsp[35 + 2*k], rsp[34 + 2*k]};
    end
    return p;
  endfunction

  // ---------------- responder + per-cycle compare ----------------
  initial begin : monitor
    logic [15:0] exp_cmd;
    logic [6:0]  a;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_quiet", {wrt, vld, init_done}, 3'b000);
        n_wrt = 0;
        n_done = 0;
        busy = 1'b0;
        done = 1'b0;
        exp_q.delete();
        hold = '0;
      end else begin
        check("init_done", init_done, n_done >= 4);
        check("vld", vld, exp_q.size() != 0);
        if (vld) begin
          n_vld++;
          if (exp_q.size() != 0) hold = exp_q.pop_front();
        end
        check("outputs", act_pkt, hold);
        if (busy) check("wt_data_hold", wt_data, cur_cmd);

        done = 1'b0;
        rd_data = 16'($urandom);
        if (wrt) begin
          check("wrt_while_busy", busy, 1'b0);
          if (n_wrt < 4) exp_cmd = cfg_words[n_wrt];
          else exp_cmd = {1'b1, 7'(34 + (n_wrt - 4) % NRD), 8'h00};
          check("wt_data", wt_data, exp_cmd);
          cur_cmd = wt_data;
          busy = 1'b1;
          dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 5));
          n_wrt++;
        end else if (busy) begin
          dly--;
          if (dly == 0) begin
            done = 1'b1;
            busy = 1'b0;
            if (cur_cmd[15]) begin
              a = cur_cmd[14:8];
              rsp[a] = regs[a];
              rd_data[7:0] = regs[a];
            end
            n_done++;
            if (n_done > 4 && (n_done - 4) % NRD == 0) exp_q.push_back(pack_exp());
          end
        end else if (inject_spur) begin
          done = 1'b1;
          inject_spur = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic raise_int();
    @(posedge clk); #3;
    INT = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    INT = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic rand_regs();
    for (int a = 34; a < 34 + 12; a++) regs[a] = 8'($urandom);
  endtask

  task automatic wait_vld(input int target, input string name);
    int b;
    b = 0;
    while (n_vld < target && b < 3000) begin
      @(posedge clk);
      b++;
    end
    check(name, n_vld, target);
    @(negedge clk); #1;
  endtask

  task automatic wait_init(input string name);
    int b;
    b = 0;
    while (init_done !== 1'b1 && b < 500) begin
      @(posedge clk); #2;
      b++;
    end
    check(name, init_done, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int lat, v0, w0, b;
    for (int a = 0; a < 128; a++) begin
      regs[a] = 8'($urandom);
      rsp[a]  = '0;
    end

    repeat (3) @(posedge clk);
    #2;
    check("reset_wt_data", wt_data, 16'h0000);
    check("reset_outputs", act_pkt, '0);
    check("reset_flags", {wrt, vld, init_done}, 3'b000);

    // Power-up wait then config sequence
    rst = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (wrt !== 1'b1 && lat < 100);
    check("first_wrt_latency", (lat >= 16 && lat <= 18) ? 17 : lat, 17);
    check("first_cfg_word", wt_data, 16'h0D02);
    wait_init("init_done_set");
    check("nemo_setup", (n_wrt == 4 && n_done == 4), 1'b1);

    // Burst 1
    rand_regs();
    regs[8'h22] = 8'h63;
    regs[8'h24] = 8'h0D;
    regs[8'h25] = 8'h7B;
    w0 = n_wrt;
    raise_int();
    wait_vld(1, "burst1_vld");
    check("burst1_roll", roll, 16'h7B0D);
    check("burst1_ptch_lo", ptch[7:0], 8'h63);
    check("burst1_reads", n_wrt - w0, NRD);

    // Burst 2
    rand_regs();
    regs[8'h27] = 8'hCD;
    regs[8'h2A] = 8'h12;
    raise_int();
    wait_vld(2, "burst2_vld");
    check("burst2_yaw_hi", yaw[15:8], 8'hCD);
    check("burst2_ay_lo", ay[7:0], 8'h12);

    // Burst 3
    rand_regs();
    regs[8'h29] = 8'h57;
    raise_int();
    wait_vld(3, "burst3_vld");
    check("burst3_ax_hi", ax[15:8], 8'h57);

    // Random bursts with random idle gaps
    for (int i = 0; i < 4; i++) begin
      rand_regs();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      raise_int();
      wait_vld(4 + i, "rand_burst_vld");
    end

    // Rises during a burst collapse into exactly one follow-up burst
    fixed_dly = 6;
    v0 = n_vld;
    w0 = n_wrt;
    rand_regs();
    raise_int();
    b = 0;
    while (n_wrt < w0 + 3 && b < 500) begin
      @(posedge clk);
      b++;
    end
    check("midburst_started", n_wrt >= w0 + 3, 1'b1);
    repeat (3) raise_int();
    wait_vld(v0 + 2, "midburst_two_vld");
    repeat (300) @(posedge clk);
    check("midburst_vld_total", n_vld - v0, 2);
    check("midburst_wrt_total", n_wrt - w0, 2 * NRD);
    fixed_dly = 0;

    // Spurious done in IDLE is ignored
    v0 = n_vld;
    w0 = n_wrt;
    inject_spur = 1'b1;
    repeat (30) @(posedge clk);
    check("spurious_no_vld", n_vld, v0);
    check("spurious_no_wrt", n_wrt, w0);
    rand_regs();
    raise_int();
    wait_vld(v0 + 1, "after_spurious_vld");

    // Reset while the 5th read of a burst is being launched
    rand_regs();
    w0 = n_wrt;
    raise_int();
    b = 0;
    while (n_wrt < w0 + 5 && b < 500) begin
      @(negedge clk);
      b++;
    end
    #1;
    check("reset_point_wrt", wrt, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_wrt", wrt, 1'b0);
    check("rst_async_outputs", act_pkt, '0);
    check("rst_async_init_done", init_done, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    v0 = n_vld;
    raise_int();  // lands during the power-up wait and must be dropped
    b = 0;
    while (wrt !== 1'b1 && b < 100) begin
      @(posedge clk); #2;
      b++;
    end
    check("restart_cfg_word", wt_data, 16'h0D02);
    wait_init("restart_init_done");
    repeat (80) @(posedge clk);
    check("early_int_ignored_wrt", n_wrt, 4);
    check("early_int_ignored_vld", n_vld, v0);

    rand_regs();
    raise_int();
    wait_vld(v0 + 1, "post_reset_vld");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inert_rd_seq.md
Name: inert_rd_seq

Overview:
- Transaction sequencer directly upstream of SPI_mnrch; drives its wrt/wt_data and consumes its done/rd_data.
- After reset, waits a power-up delay, then writes the iNEMO configuration registers (INT on data-ready, accel/gyro ODR, rounding).
- On each data-ready INT, performs a burst of byte reads and assembles 16-bit pitch/roll/yaw rates and X/Y accelerations.
- Presents the assembled values to the flight-control datapath with a one-cycle valid pulse.

Parameters:
- INIT_WAIT, 16'hFFFF, clk cycles held idle after reset before the first config write (bench uses 16'h0010).
- INT_SYNC_STG, 2, synchronizer flop stages on INT (min 2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- INT  in  1  iNEMO interrupt, asynchronous to clk
- done  in  1  SPI_mnrch transaction complete (1-cycle pulse)
- rd_data  in  16  SPI_mnrch read data; only [7:0] significant
- wrt  out  1  start SPI transaction (1-cycle pulse)
- wt_data  out  16  SPI command word
- ptch  out  16  pitch rate, signed
- roll  out  16  roll rate, signed
- yaw  out  16  yaw rate, signed
- ax  out  16  X acceleration, signed
- ay  out  16  Y acceleration, signed
- vld  out  1  1-cycle pulse; all data outputs updated this cycle
- init_done  out  1  high once the config sequence has completed

Behaviour:
- Reset values: wrt=0, wt_data=0, all data outputs=0, vld=0, init_done=0, state=PWR_WAIT, 16-bit timer=0, pending=0.
- States: PWR_WAIT -> CFG_ISSUE -> CFG_WAIT -> IDLE -> RD_ISSUE -> RD_WAIT -> COMMIT -> IDLE.
- PWR_WAIT: timer counts up; when timer==INIT_WAIT, go to CFG_ISSUE.
- Config words, in order: 16'h0D02, 16'h1062, 16'h1162, 16'h1460.
- CFG_ISSUE: wrt=1 for exactly 1 cycle; wt_data = current word; then CFG_WAIT.
- CFG_WAIT: on done, advance the index. After the 4th done, set init_done=1 (sticky until reset) and go to IDLE.
- Read command = {1'b1, addr[6:0], 8'h00}.
- Read order: ptch L/H 0x22/0x23, roll L/H 0x24/0x25, yaw L/H 0x26/0x27, ax L/H 0x28/0x29, ay L/H 0x2A/0x2B. Total 10 transactions.
- wt_data is held stable from the wrt cycle until done. wrt is never asserted while a transaction is outstanding.
- On done in RD_WAIT: rd_data[7:0] is captured into a shadow low/high byte.
- COMMIT: shadow registers are copied to the outputs and vld=1 for one cycle. Latency from last done to vld = 1 cycle. Outputs hold between bursts.
- INT handling:
  - INT passes through INT_SYNC_STG flops; a rising edge of the synchronized INT sets pending.
  - IDLE with pending=1: clear pending, go to RD_ISSUE.
  - A rising edge during a burst sets pending, giving exactly one follow-up burst; further edges are merged.
  - A rising edge during PWR_WAIT or config is ignored (pending is not set before init_done).
  - A rising edge in the same cycle as a pending clear sets pending again; set wins.
- done arriving in any state other than CFG_WAIT/RD_WAIT is ignored.
- Reset mid-transaction: immediate return to PWR_WAIT, wrt deasserted, partial shadow data discarded.

Optional Feature:
- INERT_AZ_EN defined: adds output az [15:0], reads 0x2C/0x2D after ay (12 transactions per burst), and az is updated at COMMIT.
- INERT_AZ_EN undefined: no az port, 10 transactions per burst.

Decomposition:
- Package inert_pkg holds:
  - state enum typedef;
  - localparams for the register addresses (0x22-0x2D) and the 4 config words;
  - read-address lookup array;
  - READ_BIT constant.
- Sub-module int_sync: parameterized synchronizer plus rising-edge detector producing the int_rise pulse.

Test Plan:
- Reset, INIT_WAIT=16: first wrt occurs 17±1 cycles after rst falls with wt_data=16'h0D02. Four config dones follow, then init_done=1 and iNEMO.NEMO_setup=1.
- First INT rise with SPI_mnrch+SPI_iNEMO1 in loop: 10 wrt pulses with wt_data upper bytes A2,A3,A4,A5,A6,A7,A8,A9,AA,AB. Then vld pulses once, with roll=16'h7B0D and ptch[7:0]=8'h63.
- Second INT: vld pulses again with yaw[15:8]=8'hCD and ay[7:0]=8'h12; third INT gives ax[15:8]=8'h57.
- Force INT rise mid-burst, plus 2 further rises: exactly one extra burst and exactly 2 vld pulses total.
- Assert rst during the 5th read of a burst: wrt=0 within 0 cycles, outputs=0, and the sequence restarts with 16'h0D02.
- Inject a spurious done in IDLE: no state change and no vld.
